sdp_bram_bw: RTL and testbench



---
 rtl/bram_pkg.sv | 30 +++
 rtl/sdp_bram_bw_core.sv | 38 +++
 rtl/sdp_bram_bw.sv | 160 ++++++++++++++++
 tb/tb_sdp_bram_bw.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared definitions for the byte-write block RAM family: clear-FSM states
// and the byte-lane merge used by collision forwarding and store-merge logic.
package bram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int unsigned MERGE_MAX_W = 256;
  localparam int unsigned MERGE_IDX_W = $clog2(MERGE_MAX_W);

  // Bit i of the result comes from new_w when lane i/byte_w is set in mask.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] mask,
    input int unsigned            byte_w
  );
    logic [MERGE_MAX_W-1:0] w_res;
    w_res = old_w;
    for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
      if (mask[MERGE_IDX_W'(i / byte_w)]) begin
        w_res[MERGE_IDX_W'(i)] = new_w[MERGE_IDX_W'(i)];
      end
    end
    return w_res;
  endfunction

endpackage

// File: rtl/sdp_bram_bw_core.sv
// Inferable simple-dual-port array: byte-enable write, registered read, no reset.
// Read returns the pre-write contents on a same-edge collision.
module sdp_bram_bw_core #(
  parameter int unsigned LEN_DATA = 32,
  parameter int unsigned LEN_ADDR = 10,
  parameter int unsigned BYTE_W   = 8,
  localparam int unsigned NB      = LEN_DATA / BYTE_W,
  localparam int unsigned DEPTH   = 2 ** LEN_ADDR
) (
  input  logic                clk,
  input  logic [NB-1:0]       i_we,
  input  logic [LEN_ADDR-1:0] i_waddr,
  input  logic [LEN_DATA-1:0] i_wdata,
  input  logic                i_re,
  input  logic [LEN_ADDR-1:0] i_raddr,
  output logic [LEN_DATA-1:0] o_rdata
);

  (* ram_style = "block" *) logic [LEN_DATA-1:0] r_mem [DEPTH];
  logic [LEN_DATA-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sdp_bram_bw.sv
// Single-clock SDP BRAM with byte enables, write-first collision forwarding,
// optional output register and a post-reset zero-fill of the whole array.
module sdp_bram_bw
  import bram_pkg::*;
#(
  parameter int unsigned LEN_DATA     = 32,
  parameter int unsigned LEN_ADDR     = 10,
  parameter int unsigned BYTE_W       = 8,
  parameter int unsigned OUT_REG      = 0,
  parameter int unsigned CLEAR_ON_RST = 1,
  localparam int unsigned NB          = LEN_DATA / BYTE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [NB-1:0]       wea,
  input  logic [LEN_ADDR-1:0] addra,
  input  logic [LEN_DATA-1:0] dina,
  input  logic                enb,
  input  logic [LEN_ADDR-1:0] addrb,
  output logic [LEN_DATA-1:0] doutb,
  output logic                rvalidb,
  output logic                init_busy
);

  localparam int unsigned         DEPTH     = 2 ** LEN_ADDR;
  localparam logic [LEN_ADDR-1:0] LAST_ADDR = LEN_ADDR'(DEPTH - 1);

  clr_state_t          r_state;
  logic [LEN_ADDR-1:0] r_clr_cnt;
  logic                r_busy;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [NB-1:0]       w_we;
  logic [LEN_ADDR-1:0] w_waddr;
  logic [LEN_DATA-1:0] w_wdata;
  logic [LEN_DATA-1:0] w_core_dout;

  logic                r_rv1;
  logic                r_coll;
  logic [NB-1:0]       r_mask;
  logic [LEN_DATA-1:0] r_din;
  logic [LEN_DATA-1:0] w_merged;
  logic [LEN_DATA-1:0] w_s1;

  logic                w_out_v;
  logic [LEN_DATA-1:0] w_out_d;
  logic [LEN_DATA-1:0] r_dout;
  logic                r_rvalid;

  // Clear FSM: one zero write per cycle, leaves via the last address only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
      r_clr_cnt <= '0;
      r_busy    <= (CLEAR_ON_RST != 0);
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_clr_cnt == LAST_ADDR) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign w_wr_acc = ena & ~r_busy;
  assign w_rd_acc = enb & ~r_busy;

  // Clear writes take over port A while busy.
  assign w_we    = r_busy ? {NB{1'b1}} : (w_wr_acc ? wea : '0);
  assign w_waddr = r_busy ? r_clr_cnt : addra;
  assign w_wdata = r_busy ? '0 : dina;

  sdp_bram_bw_core #(
    .LEN_DATA (LEN_DATA),
    .LEN_ADDR (LEN_ADDR),
    .BYTE_W   (BYTE_W)
  ) u_core (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_acc),
    .i_raddr (addrb),
    .o_rdata (w_core_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rv1  <= 1'b0;
      r_coll <= 1'b0;
    end else begin
      r_rv1  <= w_rd_acc;
      r_coll <= w_wr_acc & w_rd_acc & (addra == addrb) & (|wea);
    end
  end

  always_ff @(posedge clk) begin
    r_mask <= wea;
    r_din  <= dina;
  end

  // The core returns old contents on a collision; overlay the written lanes.
  assign w_merged = LEN_DATA'(byte_merge(MERGE_MAX_W'(w_core_dout), MERGE_MAX_W'(r_din),
                                         MERGE_MAX_W'(r_mask), BYTE_W));
  assign w_s1     = r_coll ? w_merged : w_core_dout;

  if (OUT_REG != 0) begin : g_oreg
    logic                r_rv2;
    logic [LEN_DATA-1:0] r_s2;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rv2 <= 1'b0;
      end else begin
        r_rv2 <= r_rv1;
      end
    end

    always_ff @(posedge clk) begin
      if (r_rv1) begin
        r_s2 <= w_s1;
      end
    end

    assign w_out_v = r_rv2;
    assign w_out_d = r_s2;
  end else begin : g_noreg
    assign w_out_v = r_rv1;
    assign w_out_d = w_s1;
  end

  // Output register holds the last response between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout   <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_out_v;
      if (w_out_v) begin
        r_dout <= w_out_d;
      end
    end
  end

  assign doutb     = r_dout;
  assign rvalidb   = r_rvalid;
  assign init_busy = r_busy;

endmodule

// File: tb/tb_sdp_bram_bw.sv
// Scoreboard bench for sdp_bram_bw: latency-1 and latency-2 instances share
// stimulus; each has its own expected-response queue and monitor.
module tb_sdp_bram_bw;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  wea;
  logic [3:0]  addra;
  logic [31:0] dina;
  logic        enb;
  logic [3:0]  addrb;

  logic [31:0] doutb0, doutb1;
  logic        rvalidb0, rvalidb1;
  logic        init_busy0, init_busy1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  sdp_bram_bw #(.LEN_DATA(32), .LEN_ADDR(4), .BYTE_W(8), .OUT_REG(0), .CLEAR_ON_RST(1)) d0 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb0), .rvalidb(rvalidb0), .init_busy(init_busy0)
  );

  sdp_bram_bw #(.LEN_DATA(32), .LEN_ADDR(4), .BYTE_W(8), .OUT_REG(1), .CLEAR_ON_RST(1)) d1 (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb1), .rvalidb(rvalidb1), .init_busy(init_busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitors: every rvalidb pulse must match the head of its queue in data and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rvalidb0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rv0_unexpected actual=pulse required=none cyc=%0d data=0x%08h", cyc, doutb0);
      end else begin
        e = q0.pop_front();
        chk("rd0_data", doutb0, e.data);
        chk("rd0_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rvalidb1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rv1_unexpected actual=pulse required=none cyc=%0d data=0x%08h", cyc, doutb1);
      end else begin
        e = q1.pop_front();
        chk("rd1_data", doutb1, e.data);
        chk("rd1_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one cycle from a negedge; a read expects its response 1 or 2 edges after acceptance.
  task automatic step(input logic e_a, input logic [3:0] w, input logic [3:0] aa,
                      input logic [31:0] da, input logic e_b, input logic [3:0] ab,
                      input logic [31:0] exp_d);
    ena   = e_a;
    wea   = w;
    addra = aa;
    dina  = da;
    enb   = e_b;
    addrb = ab;
    if (e_b) begin
      q0.push_back('{data: exp_d, cyc: cyc + 2});
      q1.push_back('{data: exp_d, cyc: cyc + 3});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  // Release reset and count busy cycles, optionally hammering both ports meanwhile.
  task automatic release_and_clear(input bit hammer);
    int n;
    n   = 0;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (init_busy0 !== 1'b1) break;
      n++;
      if (hammer) begin
        ena   = 1'b1;
        wea   = 4'hF;
        addra = i[3:0];
        dina  = 32'hDEADBEEF;
        enb   = 1'b1;
        addrb = i[3:0];
      end
      @(negedge clk);
    end
    ena = 1'b0; wea = 4'h0; enb = 1'b0;
    chk("busy_cycles", 32'(n), 32'd16);
    chk("busy1_done", {31'b0, init_busy1}, 32'd0);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 16; a++) step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a[3:0], 32'h0);
    idle(4);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; wea = 4'h0; addra = 4'h0; dina = 32'h0; enb = 1'b0; addrb = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_doutb0", doutb0, 32'h0);
    chk("rst_doutb1", doutb1, 32'h0);
    chk("rst_rvalid0", {31'b0, rvalidb0}, 32'd0);
    chk("rst_rvalid1", {31'b0, rvalidb1}, 32'd0);
    chk("rst_busy0", {31'b0, init_busy0}, 32'd1);
    chk("rst_busy1", {31'b0, init_busy1}, 32'd1);

    // Clear with requests presented throughout; none may land.
    release_and_clear(1'b1);
    read_all_zero();

    // Byte-enable write then immediate read.
    step(1'b1, 4'hF, 4'd5, 32'h11223344, 1'b0, 4'd0, 32'h0);
    step(1'b1, 4'h5, 4'd5, 32'hAABBCCDD, 1'b0, 4'd0, 32'h0);
    step(1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd5, 32'h11BB33DD);

    // Same-address collision, then a different-address write alongside a read.
    step(1'b1, 4'hF, 4'd7, 32'h01020304, 1'b0, 4'd0, 32'h0);
    step(1'b1, 4'h8, 4'd7, 32'hFFEEDDCC, 1'b1, 4'd7, 32'hFF020304);
    step(1'b1, 4'hF, 4'd8, 32'h00000055, 1'b1, 4'd7, 32'hFF020304);
    step(1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd8, 32'h00000055);
    step(1'b1, 4'h0, 4'd8, 32'hFFFFFFFF, 1'b1, 4'd8, 32'h00000055);
    idle(4);

    // Back-to-back reads of addrs 0..3 holding 0..3.
    for (int a = 0; a < 4; a++) step(1'b1, 4'hF, a[3:0], 32'(a), 1'b0, 4'd0, 32'h0);
    for (int a = 0; a < 4; a++) step(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, a[3:0], 32'(a));
    idle(4);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    // Reset: output registers return to zero.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst2_doutb0", doutb0, 32'h0);
    chk("rst2_doutb1", doutb1, 32'h0);
    chk("rst2_busy0", {31'b0, init_busy0}, 32'd1);

    // Reset mid-clear restarts the full sequence.
    rst = 1'b0;
    repeat (9) @(negedge clk);
    chk("midclr_busy", {31'b0, init_busy0}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    release_and_clear(1'b0);
    read_all_zero();

    chk("q0_final", 32'(q0.size()), 32'd0);
    chk("q1_final", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
